// File: rtl/rr_mux41_arbiter.sv
// rr_mux41_arbiter: 4-requester round-robin arbiter driving a 4:1 data mux.
//
// Parameters
//   WIDTH    - width of each data input and of out
//   MAX_HOLD - maximum grant tenure in cycles while other requests are pending (2..255)
//
// Ports
//   clk       - clock, all state updates on the rising edge
//   rst_n     - asynchronous active-low reset
//   req       - request vector; bit i requests the path for in(i+1)
//   in1..in4  - requester data words
//   gnt       - registered grant, one-hot or all-zero
//   select    - registered mux select, index of the granted requester
//   out       - selected data word, zero while nothing is granted
//   out_valid - high while a grant is active
module rr_mux41_arbiter #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   output logic [3:0]       gnt,
   output logic [1:0]       select,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);

   typedef enum logic {StIdle, StGrant} state_e;

   localparam logic [7:0] HoldMax = 8'(MAX_HOLD - 1);

   state_e     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] select_q, select_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;

   logic [3:0] others;
   logic [3:0] pick_vec;
   logic       grant_new;
   logic [1:0] win;

   // Scan from ptr upwards (mod 4); the lowest offset with a request wins.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] w;
      logic [1:0] idx;
      w = p;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (r[idx]) w = idx;
      end
      return w;
   endfunction

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      select_d   = select_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      grant_new  = 1'b0;
      pick_vec   = 4'b0000;
      // Requests from everyone except the current owner.
      others     = req & ~gnt_q;

      unique case (state_q)
         StIdle: begin
            if (|req) begin
               grant_new = 1'b1;
               pick_vec  = req;
            end
         end
         StGrant: begin
            if (req[select_q] && ((others == 4'b0000) || (hold_cnt_q != HoldMax))) begin
               // Owner keeps the grant: alone, or tenure not yet exhausted.
               if (hold_cnt_q != HoldMax) hold_cnt_d = hold_cnt_q + 8'd1;
            end else if (|others) begin
               // Tenure exhausted or owner released: hand over with no idle bubble.
               grant_new = 1'b1;
               pick_vec  = others;
            end else begin
               state_d = StIdle;
               gnt_d   = 4'b0000;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
         end
      endcase

      win = rr_pick(pick_vec, ptr_q);

      if (grant_new) begin
         state_d    = StGrant;
         gnt_d      = 4'b0001 << win;
         select_d   = win;
         ptr_d      = win + 2'd1;
         hold_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         gnt_q      <= 4'b0000;
         select_q   <= 2'd0;
         ptr_q      <= 2'd0;
         hold_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         select_q   <= select_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   always_comb begin
      out = '0;
      if (|gnt_q) begin
         unique case (select_q)
            2'd0: out = in1;
            2'd1: out = in2;
            2'd2: out = in3;
            2'd3: out = in4;
            default: out = '0;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign select    = select_q;
   assign out_valid = |gnt_q;

endmodule

// File: tb/tb_rr_mux41_arbiter.sv
// Bench for rr_mux41_arbiter: directed scenarios plus a random run, with a behavioural
// reference model feeding an expectation queue that is drained one entry per clock edge.
module tb_rr_mux41_arbiter;

   localparam int unsigned Width   = 4;
   localparam int unsigned MaxHold = 8;

   logic             clk;
   logic             rst_n;
   logic [3:0]       req;
   logic [Width-1:0] in1, in2, in3, in4;
   logic [3:0]       gnt;
   logic [1:0]       select;
   logic [Width-1:0] out;
   logic             out_valid;

   rr_mux41_arbiter #(
      .WIDTH    (Width),
      .MAX_HOLD (MaxHold)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .in4       (in4),
      .gnt       (gnt),
      .select    (select),
      .out       (out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
   } exp_t;

   exp_t             sb[$];
   logic [Width-1:0] din[4];
   int               n_checks;
   int               n_fail;

   // Reference model state
   logic [3:0]  m_gnt;
   logic [1:0]  m_sel;
   logic [1:0]  m_ptr;
   int unsigned m_cnt;

   function automatic logic [1:0] tb_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      for (int k = 0; k < 4; k++) begin
         idx = p + 2'(k);
         if (r[idx]) return idx;
      end
      return 2'd0;
   endfunction

   task automatic model_reset();
      m_gnt = 4'b0000;
      m_sel = 2'd0;
      m_ptr = 2'd0;
      m_cnt = 0;
      sb.delete();
   endtask

   task automatic model_grant(input logic [1:0] k);
      m_gnt = 4'b0001 << k;
      m_sel = k;
      m_ptr = k + 2'd1;
      m_cnt = 0;
   endtask

   task automatic model_edge(input logic [3:0] r);
      logic [3:0] oth;
      if (m_gnt == 4'b0000) begin
         if (r != 4'b0000) model_grant(tb_pick(r, m_ptr));
      end else begin
         oth = r & ~m_gnt;
         if (r[m_sel] && oth == 4'b0000) begin
            if (m_cnt < MaxHold - 1) m_cnt++;
         end else if (r[m_sel] && m_cnt < MaxHold - 1) begin
            m_cnt++;
         end else if (oth != 4'b0000) begin
            model_grant(tb_pick(oth, m_ptr));
         end else begin
            m_gnt = 4'b0000;
         end
      end
   endtask

   // Drive req for one cycle, push the model's prediction, sample #1 after the edge.
   task automatic tick(input logic [3:0] r);
      req = r;
      model_edge(r);
      sb.push_back('{gnt: m_gnt, sel: m_sel});
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req   = 4'b0000;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req   = 4'b1111;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_gnt: got %b expected 0000", gnt);
      end
      n_checks++;
      if (select !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_select: got %0d expected 0", select);
      end
      n_checks++;
      if (out !== '0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out: got out=%h valid=%b expected 0/0", out, out_valid);
      end
      n_checks++;
      if (dut.ptr_q !== 2'd0 || dut.hold_cnt_q !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_ptr_cnt: got ptr=%0d cnt=%0d expected 0/0", dut.ptr_q,
                  dut.hold_cnt_q);
      end
   endtask

   task automatic test_basic();
      exp_t e;
      apply_reset();
      tick(4'b0001);
      e = sb.pop_front();
      n_checks++;
      if (gnt !== 4'b0001 || select !== 2'd0 || gnt !== e.gnt) begin
         n_fail++;
         $display("FAIL basic_grant: got gnt=%b sel=%0d expected 0001/0", gnt, select);
      end
      n_checks++;
      if (out !== 4'h1 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_out: got out=%h valid=%b expected 1/1", out, out_valid);
      end
      tick(4'b0000);
      e = sb.pop_front();
      n_checks++;
      if (gnt !== 4'b0000 || out !== '0 || out_valid !== 1'b0 || gnt !== e.gnt) begin
         n_fail++;
         $display("FAIL basic_release: got gnt=%b out=%h valid=%b expected 0000/0/0", gnt, out,
                  out_valid);
      end
      n_checks++;
      if (select !== 2'd0) begin
         n_fail++;
         $display("FAIL basic_select_hold: got %0d expected 0", select);
      end
   endtask

   task automatic test_rotation();
      exp_t       e;
      int         own;
      logic [3:0] ev;
      apply_reset();
      for (int t = 0; t < 40; t++) begin
         tick(4'b1111);
         e   = sb.pop_front();
         own = (t / 8) % 4;
         ev  = 4'b0001 << own;
         n_checks++;
         if (gnt !== ev || gnt !== e.gnt || out !== din[own]) begin
            n_fail++;
            $display("FAIL rotation_cycle%0d: got gnt=%b out=%h expected %b/%h", t, gnt, out, ev,
                     din[own]);
         end
      end
   endtask

   task automatic test_handoff();
      exp_t       e;
      logic [3:0] seq[5];
      seq = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1000};
      apply_reset();
      foreach (seq[i]) begin
         tick(seq[i]);
         e = sb.pop_front();
         n_checks++;
         if (out_valid !== 1'b1 || gnt !== e.gnt || select !== e.sel) begin
            n_fail++;
            $display("FAIL handoff_step%0d: got gnt=%b sel=%0d valid=%b expected %b/%0d/1", i,
                     gnt, select, out_valid, e.gnt, e.sel);
         end
      end
      n_checks++;
      if (gnt !== 4'b1000 || select !== 2'd3 || out !== 4'hF) begin
         n_fail++;
         $display("FAIL handoff_final: got gnt=%b sel=%0d out=%h expected 1000/3/F", gnt, select,
                  out);
      end
   endtask

   task automatic test_hold();
      exp_t e;
      int   bad;
      apply_reset();
      bad = 0;
      for (int t = 0; t < 50; t++) begin
         tick(4'b0100);
         e = sb.pop_front();
         if (gnt !== 4'b0100 || gnt !== e.gnt) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL hold_gnt: got %0d cycles off 0100 expected 0", bad);
      end
      n_checks++;
      if (dut.hold_cnt_q !== 8'(MaxHold - 1)) begin
         n_fail++;
         $display("FAIL hold_cnt_sat: got %0d expected %0d", dut.hold_cnt_q, MaxHold - 1);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      apply_reset();
      tick(4'b0010);
      tick(4'b0010);
      tick(4'b0010);
      sb.delete();
      n_checks++;
      if (gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL midreset_pre: got %b expected 0010", gnt);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (gnt !== 4'b0000 || select !== 2'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_async: got gnt=%b sel=%0d valid=%b expected 0000/0/0", gnt,
                  select, out_valid);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(4'b1010);
      e = sb.pop_front();
      n_checks++;
      if (gnt !== 4'b0010 || select !== 2'd1 || out !== 4'h3 || gnt !== e.gnt) begin
         n_fail++;
         $display("FAIL midreset_rearb: got gnt=%b sel=%0d out=%h expected 0010/1/3", gnt,
                  select, out);
      end
   endtask

   task automatic test_random();
      exp_t       e;
      logic [3:0] r;
      int         w[4];
      int         wmax;
      logic [Width-1:0] eo;
      apply_reset();
      r = 4'b0000;
      foreach (w[i]) w[i] = 0;
      for (int t = 0; t < 10000; t++) begin
         for (int i = 0; i < 4; i++) begin
            if (r[i]) r[i] = ($urandom_range(0, 7) != 0);
            else      r[i] = ($urandom_range(0, 3) == 0);
         end
         tick(r);
         e  = sb.pop_front();
         eo = (e.gnt == 4'b0000) ? '0 : din[e.sel];
         n_checks++;
         if (gnt !== e.gnt || select !== e.sel || out !== eo) begin
            n_fail++;
            $display("FAIL random_model_c%0d: got gnt=%b sel=%0d out=%h expected %b/%0d/%h", t,
                     gnt, select, out, e.gnt, e.sel, eo);
         end
         n_checks++;
         if ($countones(gnt) > 1 || $isunknown(gnt)) begin
            n_fail++;
            $display("FAIL random_onehot_c%0d: got %b expected one-hot or zero", t, gnt);
         end
         wmax = 0;
         for (int i = 0; i < 4; i++) begin
            if (r[i] && !gnt[i]) w[i]++;
            else                 w[i] = 0;
            if (w[i] > wmax) wmax = w[i];
         end
         n_checks++;
         if (wmax > 3 * MaxHold + 1) begin
            n_fail++;
            $display("FAIL random_starve_c%0d: got wait %0d expected <= %0d", t, wmax,
                     3 * MaxHold + 1);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      din      = '{4'h1, 4'h3, 4'h7, 4'hF};
      in1      = din[0];
      in2      = din[1];
      in3      = din[2];
      in4      = din[3];
      req      = 4'b0000;
      rst_n    = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_rotation();
      test_handoff();
      test_hold();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_mux41_arbiter.md
RR_MUX41_ARBITER -- requirements
Module: rr_mux41_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the width of each data input and of out.
REQ-002 Parameter MAX_HOLD, default 8, SHALL set the maximum grant tenure in cycles while other requests are pending; legal range 2..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  4  SHALL carry requests; bit i requests the path for input in(i+1).
REQ-006 in1, in2, in3, in4  input  WIDTH each  SHALL be the requester data words.
REQ-007 gnt  output  4  SHALL be the registered grant, one-hot or all-zero.
REQ-008 select  output  2  SHALL be the registered mux select, equal to the index of the granted requester.
REQ-009 out  output  WIDTH  SHALL be the combinational selection of in1..in4 by select, forced to zero when gnt is zero.
REQ-010 out_valid  output  1  SHALL equal |gnt.

Function
REQ-011 The FSM SHALL have two states, IDLE (gnt=0) and GRANT (exactly one gnt bit set).
REQ-012 Round-robin pointer ptr (2 bits) SHALL name the highest-priority index; priority then descends ptr, ptr+1, ptr+2, ptr+3, mod 4.
REQ-013 On every new grant to index k, ptr SHALL become (k+1) mod 4 on the same edge that gnt is loaded.
REQ-014 IDLE: if req is nonzero at an edge, the round-robin winner SHALL be granted at that edge (gnt visible one cycle after req is sampled); if req is zero, the state SHALL stay IDLE.
REQ-015 GRANT, owner c: a 2-bit... (see REQ-016..019); hold_cnt SHALL clear to 0 on each new grant and increment each cycle in GRANT, saturating at MAX_HOLD-1.
REQ-016 GRANT, req[c]=1 and no other req bit set: the grant SHALL be held regardless of hold_cnt.
REQ-017 GRANT, req[c]=1, another req bit set, hold_cnt=MAX_HOLD-1: the grant SHALL pass at that edge to the round-robin winner among req with bit c masked.
REQ-018 GRANT, req[c]=0: if another req bit is set, the grant SHALL pass at that edge to the round-robin winner (no idle bubble); otherwise the FSM SHALL enter IDLE with gnt=0.
REQ-019 A requester that drops req and re-raises it in the same cycle the grant moves SHALL compete normally under the updated ptr.
REQ-020 select SHALL update only on a new grant and SHALL hold its last value in IDLE.
REQ-021 A pending requester SHALL be granted within 3*MAX_HOLD+1 cycles of asserting req while it keeps req high (no starvation).
REQ-022 gnt SHALL never have more than one bit set, including on transition edges.

Reset
REQ-023 While rst_n=0: gnt=0, select=0, out=0, out_valid=0, ptr=0, hold_cnt=0, state=IDLE, all asynchronously.
REQ-024 Reset asserted during GRANT SHALL drop gnt immediately with no completion of tenure; after release the first arbitration SHALL use ptr=0.
REQ-025 The first edge after rst_n rises SHALL be a normal arbitration edge.

Verification
REQ-026 in1=1, in2=3, in3=7, in4=F, req=0001 from reset -> next cycle gnt=0001, select=0, out=1, out_valid=1; req=0 -> next cycle gnt=0, out=0.
REQ-027 req=1111 held, MAX_HOLD=8 -> gnt rotates 0001,0010,0100,1000,0001, each tenure exactly 8 cycles; out follows 1,3,7,F.
REQ-028 Owner index 1 drops req while req[3]=1 -> next edge gnt=1000, select=3, out=F, no out_valid gap.
REQ-029 req=0100 alone held 50 cycles -> gnt=0100 constant, no rotation, hold_cnt saturated.
REQ-030 rst_n pulsed low mid-tenure with gnt=0010 -> gnt=0, select=0 immediately; after release with req=1010 -> gnt=0010 (ptr=0 scan order 0,1,2,3).
REQ-031 Random req for 10000 cycles -> one-hot-or-zero gnt every cycle and every held request granted within 25 cycles.
